// File: rtl/index_lut_ctrl.sv
// Sequencer for the four-bank index ROM: issues `count` row reads from a base address
// and streams the retimed rows through a 4-deep valid/ready FIFO. Optional INDEX_LUT_CTRL_ABORT_EN adds `abort`.
module index_lut_ctrl #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              angle_or_planar,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [5:0]        count,
  output logic              lut_rden,
  output logic [ADDR_W-1:0] lut_addr,
  input  logic [DATA_W-1:0] lut_q1,
  input  logic [DATA_W-1:0] lut_q2,
  input  logic [DATA_W-1:0] lut_q3,
  input  logic [DATA_W-1:0] lut_q4,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_idx1,
  output logic [DATA_W-1:0] out_idx2,
  output logic [DATA_W-1:0] out_idx3,
  output logic [DATA_W-1:0] out_idx4,
  output logic              out_last,
  output logic              busy,
  output logic              done
`ifdef INDEX_LUT_CTRL_ABORT_EN
  ,
  input  logic              abort
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2} state_t;

  state_t              state_r, state_s, fsm_next_s;
  logic                planar_r;
  logic [ADDR_W-1:0]   base_r;
  logic [6:0]          count_r, row_r;
  logic                s1_v_r, s1_planar_r, s1_last_r;
  logic                s2_v_r, s2_planar_r, s2_last_r;
  logic [4*DATA_W-1:0] data_mem_r [4];
  logic [3:0]          last_mem_r;
  logic [1:0]          wr_ptr_r, rd_ptr_r;
  logic [2:0]          occ_r;
  logic                lut_rden_r;
  logic [ADDR_W-1:0]   lut_addr_r;
  logic                busy_r, done_r;
  logic                abort_s, accept_s, issue_s, last_issue_s, drained_s, done_s;
  logic                push_s, pop_s, room_s;
  logic [2:0]          pending_s;

`ifdef INDEX_LUT_CTRL_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  // Occupancy plus in-flight reads bounds the FIFO, so it can never overflow.
  assign push_s    = s2_v_r;
  assign pop_s     = (occ_r != 3'd0) && out_ready;
  assign pending_s = occ_r + {2'b00, s1_v_r} + {2'b00, s2_v_r};
  assign room_s    = (pending_s < 3'd4);

  // Next-state and issue decision.
  always_comb begin
    fsm_next_s   = state_r;
    accept_s     = 1'b0;
    issue_s      = 1'b0;
    last_issue_s = 1'b0;
    drained_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          accept_s   = 1'b1;
          fsm_next_s = ISSUE;
        end else begin
          fsm_next_s = IDLE;
        end
      end
      ISSUE: begin
        issue_s      = room_s;
        last_issue_s = room_s && (row_r == (count_r - 7'd1));
        if (last_issue_s) begin
          fsm_next_s = DRAIN;
        end else begin
          fsm_next_s = ISSUE;
        end
      end
      DRAIN: begin
        // Done once the final beat leaves on this edge and nothing is still in flight.
        drained_s = !s1_v_r && !s2_v_r &&
                    ((occ_r == 3'd0) || ((occ_r == 3'd1) && pop_s));
        if (drained_s) begin
          fsm_next_s = IDLE;
        end else begin
          fsm_next_s = DRAIN;
        end
      end
      default: fsm_next_s = IDLE;
    endcase
    state_s = abort_s ? IDLE : fsm_next_s;
    done_s  = drained_s && !abort_s;
  end

  // FSM state, latched job parameters, row counter and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      planar_r <= 1'b0;
      base_r   <= {ADDR_W{1'b0}};
      count_r  <= 7'd0;
      row_r    <= 7'd0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != IDLE);
      done_r  <= done_s;
      if (accept_s && !abort_s) begin
        planar_r <= !angle_or_planar;
        base_r   <= base_addr;
        count_r  <= (count == 6'd0) ? 7'd64 : {1'b0, count};
        row_r    <= 7'd0;
      end else if (issue_s) begin
        row_r <= row_r + 7'd1;
      end
    end
  end

  // ROM request registers and the 2-stage {planar, last} tag pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lut_rden_r  <= 1'b0;
      lut_addr_r  <= {ADDR_W{1'b0}};
      s1_v_r      <= 1'b0;
      s1_planar_r <= 1'b0;
      s1_last_r   <= 1'b0;
      s2_v_r      <= 1'b0;
      s2_planar_r <= 1'b0;
      s2_last_r   <= 1'b0;
    end else if (abort_s) begin
      lut_rden_r <= 1'b0;
      s1_v_r     <= 1'b0;
      s2_v_r     <= 1'b0;
    end else begin
      lut_rden_r  <= issue_s && !planar_r;
      s1_v_r      <= issue_s;
      s1_planar_r <= planar_r;
      s1_last_r   <= last_issue_s;
      s2_v_r      <= s1_v_r;
      s2_planar_r <= s1_planar_r;
      s2_last_r   <= s1_last_r;
      if (issue_s) begin
        lut_addr_r <= base_r + ADDR_W'(row_r);
      end
    end
  end

  // Output FIFO: stage-2 beats are written, head pops on valid & ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r   <= 2'd0;
      rd_ptr_r   <= 2'd0;
      occ_r      <= 3'd0;
      last_mem_r <= 4'd0;
      for (int i = 0; i < 4; i++) begin
        data_mem_r[i] <= {(4*DATA_W){1'b0}};
      end
    end else if (abort_s) begin
      wr_ptr_r <= 2'd0;
      rd_ptr_r <= 2'd0;
      occ_r    <= 3'd0;
    end else begin
      if (push_s) begin
        data_mem_r[wr_ptr_r] <= s2_planar_r ? {(4*DATA_W){1'b0}} : {lut_q4, lut_q3, lut_q2, lut_q1};
        last_mem_r[wr_ptr_r] <= s2_last_r;
        wr_ptr_r             <= wr_ptr_r + 2'd1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 2'd1;
      end
      occ_r <= occ_r + {2'b00, push_s} - {2'b00, pop_s};
    end
  end

  assign lut_rden  = lut_rden_r;
  assign lut_addr  = lut_addr_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign out_valid = (occ_r != 3'd0);
  assign out_last  = last_mem_r[rd_ptr_r];
  assign out_idx1  = data_mem_r[rd_ptr_r][DATA_W-1:0];
  assign out_idx2  = data_mem_r[rd_ptr_r][2*DATA_W-1:DATA_W];
  assign out_idx3  = data_mem_r[rd_ptr_r][3*DATA_W-1:2*DATA_W];
  assign out_idx4  = data_mem_r[rd_ptr_r][4*DATA_W-1:3*DATA_W];

endmodule

// File: tb/tb_index_lut_ctrl.sv
// Self-checking bench for index_lut_ctrl: a ROM model, a beat/address scoreboard that
// checks every cycle, and directed jobs with hand-computed timing and data.
module tb_index_lut_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       angle_or_planar = 1'b1;
  logic [8:0] base_addr = 9'h000;
  logic [5:0] count = 6'd0;
  logic       out_ready = 1'b1;
  logic       lut_rden;
  logic [8:0] lut_addr;
  logic [7:0] lut_q1 = 8'h00, lut_q2 = 8'h00, lut_q3 = 8'h00, lut_q4 = 8'h00;
  logic       out_valid, out_last, busy, done;
  logic [7:0] out_idx1, out_idx2, out_idx3, out_idx4;
`ifdef INDEX_LUT_CTRL_ABORT_EN
  logic       abort = 1'b0;
`endif

  int total = 0;
  int bad = 0;

  index_lut_ctrl #(.ADDR_W(9), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .angle_or_planar(angle_or_planar),
    .base_addr(base_addr), .count(count), .lut_rden(lut_rden), .lut_addr(lut_addr),
    .lut_q1(lut_q1), .lut_q2(lut_q2), .lut_q3(lut_q3), .lut_q4(lut_q4),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_idx1(out_idx1), .out_idx2(out_idx2), .out_idx3(out_idx3), .out_idx4(out_idx4),
    .out_last(out_last), .busy(busy), .done(done)
`ifdef INDEX_LUT_CTRL_ABORT_EN
    , .abort(abort)
`endif
  );

  always #5 clk = ~clk;

  // ROM contents: bank k holds b + 0x11*k, b = addr[7:0] ^ 0x5A ^ (addr[8] << 7).
  function automatic logic [31:0] rom_word(input logic [8:0] a);
    logic [7:0] b;
    b = a[7:0] ^ 8'h5A ^ {a[8], 7'h00};
    rom_word = {b + 8'h33, b + 8'h22, b + 8'h11, b};
  endfunction

  always @(posedge clk) begin
    if (lut_rden) {lut_q4, lut_q3, lut_q2, lut_q1} <= rom_word(lut_addr);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard model: expected beats and ROM addresses are queued per accepted job.
  logic [32:0] exp_beats[$];
  logic [8:0]  exp_addr[$];
  logic        busy_m = 1'b0, done_exp = 1'b0, prev_stall = 1'b0, hs, hs_last, abort_m, accept_m;
  logic [32:0] prev_beat = 33'h0, cur_beat, e_beat;
  logic [8:0]  m_addr;
  int          m_n;

  initial begin
    forever begin
      @(negedge clk);
      cur_beat = {out_last, out_idx4, out_idx3, out_idx2, out_idx1};
      if (!rst_n) begin
        chk("reset_outputs", {lut_rden, lut_addr, out_valid, out_last, busy, done,
                              out_idx4, out_idx3, out_idx2, out_idx1}, 64'h0);
        exp_beats.delete();
        exp_addr.delete();
        busy_m = 1'b0; done_exp = 1'b0; prev_stall = 1'b0;
      end else begin
        chk("done", done, done_exp);
        chk("busy", busy, busy_m);
        if (lut_rden) begin
          if (exp_addr.size() == 0) chk("rden_unexpected", lut_rden, 1'b0);
          else chk("lut_addr", lut_addr, exp_addr.pop_front());
        end
        if (prev_stall) begin
          chk("stall_valid", out_valid, 1'b1);
          if (out_valid) chk("stall_hold", cur_beat, prev_beat);
        end
        hs = out_valid && out_ready;
        hs_last = 1'b0;
        if (hs) begin
          if (exp_beats.size() == 0) chk("beat_unexpected", out_valid, 1'b0);
          else begin
            e_beat = exp_beats.pop_front();
            chk("beat", cur_beat, e_beat);
            hs_last = e_beat[32];
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_beat = cur_beat;
        done_exp = hs && hs_last;
        abort_m = 1'b0;
`ifdef INDEX_LUT_CTRL_ABORT_EN
        abort_m = abort;
`endif
        if (abort_m) begin
          exp_beats.delete();
          exp_addr.delete();
          busy_m = 1'b0; done_exp = 1'b0; prev_stall = 1'b0;
        end else begin
          accept_m = start && !busy_m;
          if (accept_m) begin
            m_n = (count == 6'd0) ? 64 : int'(count);
            for (int i = 0; i < m_n; i++) begin
              m_addr = base_addr + 9'(i);
              exp_beats.push_back({(i == m_n - 1), (angle_or_planar ? rom_word(m_addr) : 32'h0)});
              if (angle_or_planar) exp_addr.push_back(m_addr);
            end
          end
          busy_m = accept_m ? 1'b1 : (done_exp ? 1'b0 : busy_m);
        end
      end
    end
  end

  task automatic launch(input logic ang, input logic [8:0] b, input logic [5:0] c);
    start = 1'b1; angle_or_planar = ang; base_addr = b; count = c;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  logic [8:0] t1_addr[4] = '{9'h010, 9'h011, 9'h012, 9'h013};
  logic [8:0] t2_addr[4] = '{9'h1FE, 9'h1FF, 9'h000, 9'h001};
  int beats, done_at, rd_seen;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Angular base 0x010, count 4, ready held high.
    launch(1'b1, 9'h010, 6'd4);
    for (int j = 0; j <= 8; j++) begin
      @(negedge clk);
      if (j >= 1 && j <= 4) begin
        chk("t1_rden", lut_rden, 1'b1);
        chk("t1_addr", lut_addr, t1_addr[j-1]);
      end
      if (j == 0 || j == 5) chk("t1_rden_low", lut_rden, 1'b0);
      if (j == 3) begin
        chk("t1_first_valid", out_valid, 1'b1);
        chk("t1_idx1", out_idx1, 8'h4A);
        chk("t1_idx4", out_idx4, 8'h7D);
      end
      if (j >= 3 && j <= 6) chk("t1_last", out_last, (j == 6));
      chk("t1_done", done, (j == 7));
      @(posedge clk); #1;
    end

    // Address wrap-around.
    launch(1'b1, 9'h1FE, 6'd4);
    for (int j = 0; j <= 8; j++) begin
      @(negedge clk);
      if (j >= 1 && j <= 4) chk("t2_addr", lut_addr, t2_addr[j-1]);
      if (j == 3) chk("t2_idx1", out_idx1, 8'h24);
      chk("t2_done", done, (j == 7));
      @(posedge clk); #1;
    end

    // Planar job, count 0 => 64 zero beats, no ROM reads.
    beats = 0; done_at = -1; rd_seen = 0;
    launch(1'b0, 9'h055, 6'd0);
    for (int j = 0; j <= 80; j++) begin
      @(negedge clk);
      if (lut_rden) rd_seen++;
      if (out_valid) chk("t3_zero", {out_idx4, out_idx3, out_idx2, out_idx1}, 32'h0);
      if (out_valid && out_ready) beats++;
      if (done) done_at = j;
      @(posedge clk); #1;
    end
    chk("t3_beats", beats, 64);
    chk("t3_done_cycle", done_at, 67);
    chk("t3_no_rden", rd_seen, 0);

    // Backpressure: count 8, out_ready low through cycle 12.
    out_ready = 1'b0;
    beats = 0; done_at = -1;
    launch(1'b1, 9'h0A0, 6'd8);
    for (int j = 0; j <= 40; j++) begin
      @(negedge clk);
      if (j >= 5 && j <= 14) chk("t4_stall_rden", lut_rden, 1'b0);
      if (j >= 6 && j <= 13) chk("t4_valid_held", out_valid, 1'b1);
      if (j == 15) chk("t4_resume_rden", lut_rden, 1'b1);
      if (out_valid && out_ready) beats++;
      if (done) done_at = j;
      @(posedge clk); #1;
      if (j == 12) out_ready = 1'b1;
    end
    chk("t4_beats", beats, 8);
    chk("t4_done_seen", (done_at > 0), 1'b1);

    // Start while busy is ignored.
    beats = 0; done_at = -1;
    launch(1'b1, 9'h040, 6'd3);
    for (int j = 0; j <= 10; j++) begin
      @(negedge clk);
      if (out_valid && out_ready) beats++;
      if (done) done_at = j;
      @(posedge clk); #1;
      if (j == 1) begin start = 1'b1; angle_or_planar = 1'b0; base_addr = 9'h100; count = 6'd5; end
      if (j == 2) start = 1'b0;
    end
    chk("t5_beats", beats, 3);
    chk("t5_done_cycle", done_at, 6);

    // Back-to-back: second start in the done cycle of the first job.
    beats = 0;
    launch(1'b1, 9'h0C0, 6'd2);
    for (int j = 0; j <= 12; j++) begin
      @(negedge clk);
      if (j == 5) chk("t6_done1", done, 1'b1);
      if (j == 6) chk("t6_busy2", busy, 1'b1);
      if (j == 8) chk("t6_gap", out_valid, 1'b0);
      if (j == 9) begin
        chk("t6_valid2", out_valid, 1'b1);
        chk("t6_idx1", out_idx1, 8'hBA);
      end
      if (j == 10) chk("t6_done2", done, 1'b1);
      if (out_valid && out_ready) beats++;
      @(posedge clk); #1;
      if (j == 4) begin start = 1'b1; angle_or_planar = 1'b1; base_addr = 9'h0E0; count = 6'd1; end
      if (j == 5) start = 1'b0;
    end
    chk("t6_beats", beats, 3);

    // Reset asserted at beat 2 of a job.
    launch(1'b1, 9'h111, 6'd8);
    for (int j = 0; j <= 3; j++) begin
      @(negedge clk);
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk("t7_async_reset", {lut_rden, lut_addr, out_valid, out_last, busy, done,
                           out_idx4, out_idx3, out_idx2, out_idx1}, 64'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int j = 0; j <= 9; j++) begin
      @(negedge clk);
      chk("t7_quiet", {done, busy, out_valid}, 3'b000);
      @(posedge clk); #1;
    end

`ifdef INDEX_LUT_CTRL_ABORT_EN
    // Abort in cycle 5 of a count-8 job, then a fresh start in cycle 6.
    done_at = -1;
    launch(1'b1, 9'h020, 6'd8);
    for (int j = 0; j <= 14; j++) begin
      @(negedge clk);
      if (j == 6) chk("t8_after_abort", {out_valid, busy, done}, 3'b000);
      if (done) done_at = j;
      @(posedge clk); #1;
      if (j == 4) abort = 1'b1;
      if (j == 5) begin abort = 1'b0; start = 1'b1; angle_or_planar = 1'b1; base_addr = 9'h030; count = 6'd2; end
      if (j == 6) start = 1'b0;
    end
    chk("t8_done_cycle", done_at, 12);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", exp_beats.size() + exp_addr.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
